// File: rtl/vga_frame_capture_if.sv
// Captured-pixel stream of vga_frame_capture.
// One recovered pixel per clock: coordinates, colour and in-view flag.
interface vga_frame_capture_if;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic [5:0] pix_rgb;
   logic       pix_valid;

   modport master (
      output pix_x, pix_y, pix_rgb, pix_valid
   );

   modport slave (
      input pix_x, pix_y, pix_rgb, pix_valid
   );
endinterface

// File: rtl/vga_frame_capture.sv
// VGA receiver: recovers x/y from TinyVGA syncs, checks lock, tracks lit bbox.
// Optional centroid outputs: define VGA_CAPTURE_CENTROID_EN.
module vga_frame_capture #(
   parameter int H_DISPLAY  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_DISPLAY  = 480,
   parameter int V_BOTTOM   = 10,
   parameter int V_SYNC     = 2,
   parameter int V_TOP      = 33,
   parameter int LOCK_LINES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] vga_in,
   vga_frame_capture_if.master pix,
   output logic       h_locked,
   output logic       v_locked,
   output logic       frame_done,
   output logic       bbox_valid,
   output logic [9:0] bbox_x0,
   output logic [9:0] bbox_x1,
   output logic [9:0] bbox_y0,
   output logic [9:0] bbox_y1,
   output logic [9:0] center_x,
   output logic [9:0] center_y
);
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_LEN    = 10'(H_TOTAL);
   localparam logic [9:0] V_LEN    = 10'(V_TOTAL);
   localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_BOTTOM);
   localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0] SAT      = 10'h3ff;
   localparam logic [3:0] LOCK_N   = 4'(LOCK_LINES);

   logic [7:0] vga_q;
   logic       hs_edge, vs_edge, x_wrap;
   logic [9:0] x_cnt, y_cnt;
   logic [9:0] line_len, frame_lines;
   logic [3:0] good_cnt;
   logic       armed, in_view, lit;
   logic [9:0] min_x, max_x, min_y, max_y;
   logic       any_lit;
   logic [9:0] nx0, nx1, ny0, ny1;
   logic       n_any;

   // Syncs are active low; an edge is the old sample high, the new one low.
   assign hs_edge = vga_q[7] & ~vga_in[7];
   assign vs_edge = vga_q[3] & ~vga_in[3];
   assign x_wrap  = ~hs_edge & (x_cnt == H_LAST);

   assign in_view = armed & (x_cnt < H_VIS) & (y_cnt < V_VIS);
   assign lit     = in_view & (pix.pix_rgb != 6'd0);

   assign pix.pix_x     = x_cnt;
   assign pix.pix_y     = y_cnt;
   assign pix.pix_valid = in_view;
   assign pix.pix_rgb   = {vga_q[0], vga_q[4], vga_q[1],
                           vga_q[5], vga_q[2], vga_q[6]};

   assign h_locked = (good_cnt == LOCK_N);

   // Input register; counters below are phased to the sample it holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vga_q <= '0;
      else        vga_q <= vga_in;
   end

   // Pixel position: syncs re-phase, otherwise free-run over the raster.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         if (hs_edge)              x_cnt <= HS_START;
         else if (x_cnt == H_LAST) x_cnt <= '0;
         else                      x_cnt <= x_cnt + 10'd1;
         if (vs_edge)              y_cnt <= VS_START;
         else if (x_wrap)          y_cnt <= (y_cnt == V_LAST) ? '0 : y_cnt + 10'd1;
      end
   end

   // Line period check feeding the horizontal lock counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_len <= '0;
         good_cnt <= '0;
      end else if (hs_edge) begin
         line_len <= 10'd1;
         if (line_len != H_LEN)     good_cnt <= '0;
         else if (good_cnt != LOCK_N) good_cnt <= good_cnt + 4'd1;
      end else if (line_len != SAT) begin
         line_len <= line_len + 10'd1;
      end
   end

   // Frame line count, vertical lock and arming on vsync.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_lines <= '0;
         v_locked    <= 1'b0;
         armed       <= 1'b0;
      end else if (vs_edge) begin
         frame_lines <= '0;
         armed       <= 1'b1;
         if (armed) v_locked <= (frame_lines == V_LEN);
      end else if (hs_edge && frame_lines != SAT) begin
         frame_lines <= frame_lines + 10'd1;
      end
   end

   // Running extremes including the pixel on the bus this cycle.
   always_comb begin
      nx0   = min_x;
      nx1   = max_x;
      ny0   = min_y;
      ny1   = max_y;
      n_any = any_lit;
      if (lit) begin
         n_any = 1'b1;
         if (x_cnt < min_x) nx0 = x_cnt;
         if (x_cnt > max_x) nx1 = x_cnt;
         if (y_cnt < min_y) ny0 = y_cnt;
         if (y_cnt > max_y) ny1 = y_cnt;
      end
   end

   // Per-frame accumulators, restarted at every vsync.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_x   <= '0;
         max_x   <= '0;
         min_y   <= '0;
         max_y   <= '0;
         any_lit <= 1'b0;
      end else if (vs_edge) begin
         min_x   <= SAT;
         max_x   <= '0;
         min_y   <= SAT;
         max_y   <= '0;
         any_lit <= 1'b0;
      end else begin
         min_x   <= nx0;
         max_x   <= nx1;
         min_y   <= ny0;
         max_y   <= ny1;
         any_lit <= n_any;
      end
   end

   // Publish the finished frame; an empty frame keeps the old box.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done <= 1'b0;
         bbox_valid <= 1'b0;
         bbox_x0    <= '0;
         bbox_x1    <= '0;
         bbox_y0    <= '0;
         bbox_y1    <= '0;
      end else begin
         frame_done <= vs_edge & armed;
         if (vs_edge && armed) begin
            bbox_valid <= n_any;
            if (n_any) begin
               bbox_x0 <= nx0;
               bbox_x1 <= nx1;
               bbox_y0 <= ny0;
               bbox_y1 <= ny1;
            end
         end
      end
   end

`ifdef VGA_CAPTURE_CENTROID_EN
   logic [10:0] sum_x, sum_y;
   assign sum_x    = {1'b0, bbox_x0} + {1'b0, bbox_x1};
   assign sum_y    = {1'b0, bbox_y0} + {1'b0, bbox_y1};
   assign center_x = bbox_valid ? sum_x[10:1] : '0;
   assign center_y = bbox_valid ? sum_y[10:1] : '0;
`else
   assign center_x = '0;
   assign center_y = '0;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a reduced raster (56x37 clocks).
// Frame table with fixed expectations plus a per-cycle reference model.
module tb_vga_frame_capture;
   localparam int HD = 40, HF = 4, HS = 6, HB = 6;
   localparam int VD = 30, VB = 2, VS = 2, VTP = 3;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VB + VS + VTP;
   localparam int LOCK = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] vga_in = 8'h00;
   logic       h_locked, v_locked, frame_done, bbox_valid;
   logic [9:0] bbox_x0, bbox_x1, bbox_y0, bbox_y1;
   logic [9:0] center_x, center_y;

   vga_frame_capture_if pix_bus ();

   vga_frame_capture #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VTP),
      .LOCK_LINES(LOCK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .vga_in(vga_in), .pix(pix_bus),
      .h_locked(h_locked), .v_locked(v_locked),
      .frame_done(frame_done), .bbox_valid(bbox_valid),
      .bbox_x0(bbox_x0), .bbox_x1(bbox_x1),
      .bbox_y0(bbox_y0), .bbox_y1(bbox_y1),
      .center_x(center_x), .center_y(center_y)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // reference model state, in source raster terms
   logic [7:0] prev_b;
   int  t, last_hs, good, hs_count;
   bit  armed_m, vlock_m, exp_done, bvalid, pv_m, acc_any;
   int  acc_x0, acc_x1, acc_y0, acc_y1;
   int  bx0, bx1, by0, by1, px_m, py_m;
   logic [5:0] prgb_m;

   // values latched when the DUT reports a finished frame
   bit done_seen, got_valid;
   int got_x0, got_x1, got_y0, got_y1, got_cx, got_cy;

   typedef struct {
      int rx0; int rx1; int ry0; int ry1;
      logic [5:0] col;
      bit rnd; int long_line; bit extra;
      bit e_done; bit chk; bit e_valid;
      int ex0; int ex1; int ey0; int ey1; int ecx; int ecy;
      bit e_hl; bit e_vl;
   } row_t;

   row_t rows[10];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pack(input bit hs, input bit vs,
                                       input logic [5:0] c);
      return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
   endfunction

   task automatic model_reset();
      prev_b = 8'h00; t = 0; last_hs = -1; good = 0; hs_count = 0;
      armed_m = 0; vlock_m = 0; exp_done = 0; bvalid = 0; pv_m = 0;
      acc_any = 0; acc_x0 = 1023; acc_x1 = 0; acc_y0 = 1023; acc_y1 = 0;
      bx0 = 0; bx1 = 0; by0 = 0; by1 = 0;
      px_m = 0; py_m = 0; prgb_m = 0;
   endtask

   // One pixel clock: check what the DUT shows for the previous sample,
   // then drive the next sample and advance the model.
   task automatic step(input logic [7:0] b, input int hc, input int vc,
                       input logic [5:0] rgb);
      @(negedge clk);
      check("pix_valid", int'(pix_bus.pix_valid), int'(pv_m));
      if (pv_m) begin
         check("pix_x", int'(pix_bus.pix_x), px_m);
         check("pix_y", int'(pix_bus.pix_y), py_m);
         check("pix_rgb", int'(pix_bus.pix_rgb), int'(prgb_m));
      end
      check("h_locked", int'(h_locked), (good >= LOCK) ? 1 : 0);
      check("v_locked", int'(v_locked), int'(vlock_m));
      check("frame_done", int'(frame_done), int'(exp_done));
      check("bbox_valid", int'(bbox_valid), int'(bvalid));
      if (exp_done) begin
         check("bbox_x0", int'(bbox_x0), bx0);
         check("bbox_x1", int'(bbox_x1), bx1);
         check("bbox_y0", int'(bbox_y0), by0);
         check("bbox_y1", int'(bbox_y1), by1);
`ifdef VGA_CAPTURE_CENTROID_EN
         check("center_x", int'(center_x), bvalid ? (bx0 + bx1) / 2 : 0);
         check("center_y", int'(center_y), bvalid ? (by0 + by1) / 2 : 0);
`else
         check("center_x", int'(center_x), 0);
         check("center_y", int'(center_y), 0);
`endif
      end
      if (frame_done) begin
         done_seen = 1;
         got_valid = bbox_valid;
         got_x0 = bbox_x0; got_x1 = bbox_x1;
         got_y0 = bbox_y0; got_y1 = bbox_y1;
         got_cx = center_x; got_cy = center_y;
      end
      vga_in = b;
      exp_done = 0;
      if (prev_b[7] && !b[7]) begin
         if (last_hs >= 0 && t - last_hs == HT)
            good = (good < LOCK) ? good + 1 : good;
         else
            good = 0;
         last_hs = t;
         hs_count++;
      end
      if (prev_b[3] && !b[3]) begin
         if (armed_m) begin
            exp_done = 1;
            vlock_m = (hs_count == VT);
            bvalid = acc_any;
            if (acc_any) begin
               bx0 = acc_x0; bx1 = acc_x1; by0 = acc_y0; by1 = acc_y1;
            end
         end
         armed_m = 1; hs_count = 0; acc_any = 0;
         acc_x0 = 1023; acc_x1 = 0; acc_y0 = 1023; acc_y1 = 0;
      end
      pv_m = armed_m && hc < HD && vc < VD;
      px_m = hc; py_m = vc; prgb_m = rgb;
      if (pv_m && rgb != 0) begin
         acc_any = 1;
         if (hc < acc_x0) acc_x0 = hc;
         if (hc > acc_x1) acc_x1 = hc;
         if (vc < acc_y0) acc_y0 = vc;
         if (vc > acc_y1) acc_y1 = vc;
      end
      prev_b = b;
      t++;
   endtask

   // Emit lines [l_first, l_end) of a frame; l_end < 0 means to the end.
   task automatic send_frame(input int rx0, input int rx1, input int ry0,
                             input int ry1, input logic [5:0] col,
                             input bit rnd, input int long_line,
                             input bit extra, input int l_first,
                             input int l_end);
      int nl, vs0, last, ext, npx;
      bit vs_n, hs_n;
      logic [5:0] rgb;
      nl   = VT + (extra ? 1 : 0);
      vs0  = VD + VB + (extra ? 1 : 0);
      last = (l_end < 0) ? nl : l_end;
      for (int li = l_first; li < last; li++) begin
         ext  = (li == long_line) ? 1 : 0;
         npx  = HT + ext;
         vs_n = !(li >= vs0 && li < vs0 + VS);
         for (int p = 0; p < npx; p++) begin
            hs_n = !(p >= HD + HF + ext && p < HD + HF + ext + HS);
            rgb = 6'd0;
            if (rnd) begin
               if ($urandom_range(0, 15) == 0) rgb = 6'($urandom);
            end else if (p >= rx0 && p <= rx1 && li >= ry0 && li <= ry1) begin
               rgb = col;
            end
            step(pack(hs_n, vs_n, rgb), p, li, rgb);
         end
      end
   endtask

   task automatic check_rst_zero(input string name);
      check(name, (|{pix_bus.pix_x, pix_bus.pix_y, pix_bus.pix_rgb,
                     pix_bus.pix_valid, h_locked, v_locked, frame_done,
                     bbox_valid, bbox_x0, bbox_x1, bbox_y0, bbox_y1,
                     center_x, center_y}) ? 1 : 0, 0);
   endtask

   initial begin
      //         rx0 rx1 ry0 ry1 col        rnd lng ext done chk val
      //         ex0 ex1 ey0 ey1 ecx ecy hl vl
      rows[0] = '{-1, -2, -1, -2, 6'd0,      0, -1, 0, 0, 0, 0,
                  0, 0, 0, 0, 0, 0, 1, 0};
      rows[1] = '{-1, -2, -1, -2, 6'd0,      0, -1, 0, 1, 1, 0,
                  0, 0, 0, 0, 0, 0, 1, 1};
      rows[2] = '{-1, -2, -1, -2, 6'd0,      0, -1, 0, 1, 1, 0,
                  0, 0, 0, 0, 0, 0, 1, 1};
      rows[3] = '{10, 10, 5, 5, 6'b110011,   0, -1, 0, 1, 1, 1,
                  10, 10, 5, 5, 10, 5, 1, 1};
      rows[4] = '{12, 20, 7, 15, 6'b101010,  0, -1, 0, 1, 1, 1,
                  12, 20, 7, 15, 16, 11, 1, 1};
      rows[5] = '{40, 55, 0, 36, 6'b111111,  0, -1, 0, 1, 1, 0,
                  12, 20, 7, 15, 0, 0, 1, 1};
      rows[6] = '{0, 39, 0, 29, 6'b000100,   0, 10, 0, 1, 1, 1,
                  0, 39, 0, 29, 19, 14, 1, 1};
      rows[7] = '{39, 39, 29, 29, 6'b000001, 0, -1, 1, 1, 1, 1,
                  39, 39, 29, 29, 39, 29, 1, 0};
      rows[8] = '{-1, -2, -1, -2, 6'd0,      1, -1, 0, 1, 0, 0,
                  0, 0, 0, 0, 0, 0, 1, 1};
      rows[9] = '{-1, -2, -1, -2, 6'd0,      1, -1, 0, 1, 0, 0,
                  0, 0, 0, 0, 0, 0, 1, 1};

      model_reset();
      repeat (3) begin
         @(negedge clk);
         check_rst_zero("reset_outputs");
      end
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         done_seen = 0;
         send_frame(rows[i].rx0, rows[i].rx1, rows[i].ry0, rows[i].ry1,
                    rows[i].col, rows[i].rnd, rows[i].long_line,
                    rows[i].extra, 0, -1);
         check("row_done", int'(done_seen), int'(rows[i].e_done));
         if (rows[i].e_done && rows[i].chk) begin
            check("row_valid", int'(got_valid), int'(rows[i].e_valid));
            check("row_x0", got_x0, rows[i].ex0);
            check("row_x1", got_x1, rows[i].ex1);
            check("row_y0", got_y0, rows[i].ey0);
            check("row_y1", got_y1, rows[i].ey1);
`ifdef VGA_CAPTURE_CENTROID_EN
            check("row_cx", got_cx, rows[i].ecx);
            check("row_cy", got_cy, rows[i].ecy);
`else
            check("row_cx", got_cx, 0);
            check("row_cy", got_cy, 0);
`endif
         end
         check("row_h_locked", int'(h_locked), int'(rows[i].e_hl));
         check("row_v_locked", int'(v_locked), int'(rows[i].e_vl));
      end

      // reset in the middle of a frame, then resume the same raster
      send_frame(5, 5, 20, 20, 6'b010101, 0, -1, 0, 0, 15);
      @(negedge clk);
      rst_n = 1'b0;
      vga_in = 8'h00;
      repeat (4) begin
         @(negedge clk);
         check_rst_zero("midframe_reset_outputs");
      end
      rst_n = 1'b1;
      model_reset();
      done_seen = 0;
      send_frame(5, 5, 20, 20, 6'b010101, 0, -1, 0, 15, -1);
      check("rearm_no_done", int'(done_seen), 0);
      done_seen = 0;
      send_frame(3, 7, 4, 9, 6'b001100, 0, -1, 0, 0, -1);
      check("post_reset_done", int'(done_seen), 1);
      check("post_reset_valid", int'(got_valid), 1);
      check("post_reset_x0", got_x0, 3);
      check("post_reset_x1", got_x1, 7);
      check("post_reset_y0", got_y0, 4);
      check("post_reset_y1", got_y1, 9);
      check("post_reset_v_locked", int'(v_locked), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
